// File: rtl/test_sequencer.sv
// Test-program sequencer: sweeps a bank of program instances one at a time,
// holding each in reset for a fixed number of cycles, then waiting for its
// finished flag (or a timeout) and accumulating per-program results.
module test_sequencer #(
    parameter int NTests      = 4,
    parameter int SelWidth    = 2,
    parameter int ResetCycles = 2,
    parameter int MaxSteps    = 1000,
    parameter int CountWidth  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  prog_reset,
    output logic [SelWidth-1:0]   prog_select,
    input  logic                  prog_finished,
    input  logic                  prog_success,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            pass_count,
    output logic [NTests-1:0]     fail_mask,
    output logic [NTests-1:0]     timeout_mask,
    output logic [CountWidth-1:0] last_steps,
    output logic                  all_passed
);

    // Reset-phase counter only needs to reach ResetCycles-1
    localparam int RcWidth = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

    localparam logic [RcWidth-1:0]    RcLast   = RcWidth'(ResetCycles - 1);
    localparam logic [RcWidth-1:0]    RcOne    = RcWidth'(1);
    localparam logic [SelWidth-1:0]   SelLast  = SelWidth'(NTests - 1);
    localparam logic [SelWidth-1:0]   SelOne   = SelWidth'(1);
    localparam logic [CountWidth-1:0] MaxCnt   = CountWidth'(MaxSteps);
    localparam logic [CountWidth-1:0] CntOne   = CountWidth'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_RUN    = 3'd2,
        S_RECORD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state_q,        state_d;
    logic [RcWidth-1:0]      rst_cnt_q,      rst_cnt_d;
    logic [CountWidth-1:0]   run_cnt_q,      run_cnt_d;
    logic [SelWidth-1:0]     sel_q,          sel_d;
    logic                    res_pass_q,     res_pass_d;
    logic                    res_timeout_q,  res_timeout_d;
    logic                    prog_reset_q,   prog_reset_d;
    logic                    busy_q,         busy_d;
    logic                    done_q,         done_d;
    logic [4:0]              pass_count_q,   pass_count_d;
    logic [NTests-1:0]       fail_mask_q,    fail_mask_d;
    logic [NTests-1:0]       timeout_mask_q, timeout_mask_d;
    logic [CountWidth-1:0]   last_steps_q,   last_steps_d;
    logic                    all_passed_q,   all_passed_d;
    logic [NTests-1:0]       sel_onehot_s;

    // One-hot decode of the program under test, used to set its result bits
    always_comb begin
        sel_onehot_s = {NTests{1'b0}};
        for (int i = 0; i < NTests; i++) begin
            sel_onehot_s[i] = (sel_q == SelWidth'(i));
        end
    end

    // Next-state and next-output logic; outputs are derived from the next state
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        run_cnt_d      = run_cnt_q;
        sel_d          = sel_q;
        res_pass_d     = res_pass_q;
        res_timeout_d  = res_timeout_q;
        pass_count_d   = pass_count_q;
        fail_mask_d    = fail_mask_q;
        timeout_mask_d = timeout_mask_q;
        last_steps_d   = last_steps_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start is only honoured here; a pulse while busy is dropped
                if (start) begin
                    state_d        = S_RESET;
                    sel_d          = {SelWidth{1'b0}};
                    rst_cnt_d      = {RcWidth{1'b0}};
                    pass_count_d   = 5'd0;
                    fail_mask_d    = {NTests{1'b0}};
                    timeout_mask_d = {NTests{1'b0}};
                    last_steps_d   = {CountWidth{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RESET: begin
                // prog_finished is deliberately not looked at while in reset
                if (rst_cnt_q == RcLast) begin
                    state_d   = S_RUN;
                    run_cnt_d = {CountWidth{1'b0}};
                end else begin
                    rst_cnt_d = rst_cnt_q + RcOne;
                end
            end
            S_RUN: begin
                // finished takes priority over a timeout on the same cycle
                if (prog_finished) begin
                    res_pass_d    = prog_success;
                    res_timeout_d = 1'b0;
                    last_steps_d  = run_cnt_q;
                    state_d       = S_RECORD;
                end else if (run_cnt_q >= MaxCnt) begin
                    res_pass_d    = 1'b0;
                    res_timeout_d = 1'b1;
                    last_steps_d  = MaxCnt;
                    state_d       = S_RECORD;
                end else begin
                    run_cnt_d = run_cnt_q + CntOne;
                end
            end
            S_RECORD: begin
                if (res_pass_q) begin
                    pass_count_d = pass_count_q + 5'd1;
                end else begin
                    fail_mask_d = fail_mask_q | sel_onehot_s;
                    if (res_timeout_q) begin
                        timeout_mask_d = timeout_mask_q | sel_onehot_s;
                    end else begin
                        timeout_mask_d = timeout_mask_q;
                    end
                end
                if (sel_q == SelLast) begin
                    state_d = S_DONE;
                end else begin
                    sel_d     = sel_q + SelOne;
                    rst_cnt_d = {RcWidth{1'b0}};
                    state_d   = S_RESET;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        prog_reset_d = (state_d != S_RUN);
        busy_d       = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_RECORD);
        done_d       = (state_d == S_DONE);
        all_passed_d = (state_d == S_DONE) && (fail_mask_d == {NTests{1'b0}});
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            rst_cnt_q      <= {RcWidth{1'b0}};
            run_cnt_q      <= {CountWidth{1'b0}};
            sel_q          <= {SelWidth{1'b0}};
            res_pass_q     <= 1'b0;
            res_timeout_q  <= 1'b0;
            prog_reset_q   <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_count_q   <= 5'd0;
            fail_mask_q    <= {NTests{1'b0}};
            timeout_mask_q <= {NTests{1'b0}};
            last_steps_q   <= {CountWidth{1'b0}};
            all_passed_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            run_cnt_q      <= run_cnt_d;
            sel_q          <= sel_d;
            res_pass_q     <= res_pass_d;
            res_timeout_q  <= res_timeout_d;
            prog_reset_q   <= prog_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_count_q   <= pass_count_d;
            fail_mask_q    <= fail_mask_d;
            timeout_mask_q <= timeout_mask_d;
            last_steps_q   <= last_steps_d;
            all_passed_q   <= all_passed_d;
        end
    end

    assign prog_reset   = prog_reset_q;
    assign prog_select  = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_count   = pass_count_q;
    assign fail_mask    = fail_mask_q;
    assign timeout_mask = timeout_mask_q;
    assign last_steps   = last_steps_q;
    assign all_passed   = all_passed_q;

endmodule
